// File: rtl/uart_rx_sampler.sv
// 8-bit UART receive front end: two-flop synchroniser, three-sample majority vote
// at each bit centre, optional even/odd parity, one-cycle result pulses.
module uart_rx_sampler #(
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY       = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       bit_in,
    output logic [7:0] byte_out,
    output logic       ready_out,
    output logic       parity_err,
    output logic       frame_err,
    output logic       busy
);

    localparam int         H        = CLKS_PER_BIT / 2;
    localparam logic [9:0] SAMP_A   = 10'(H - 1);
    localparam logic [9:0] SAMP_B   = 10'(H);
    localparam logic [9:0] DECIDE   = 10'(H + 1);
    localparam logic [9:0] CNT_LAST = 10'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY_BIT,
        STOP,
        WAIT_HIGH
    } state_t;

    state_t     state;
    state_t     state_next;
    logic       sync1;
    logic       rx_s;
    logic [9:0] cnt;
    logic [2:0] bit_idx;
    logic [7:0] shreg;
    logic       samp_a;
    logic       samp_b;
    logic       par_bit;
    logic       maj;
    logic       at_decide;
    logic       cell_end;
    logic       byte_done;
    logic       frame_bad;
    logic       par_expect;
    logic       par_bad;

    // The third vote is the live synchronised line at the decision cycle.
    assign maj       = (samp_a & samp_b) | (samp_a & rx_s) | (samp_b & rx_s);
    assign at_decide = (cnt == DECIDE);
    assign cell_end  = (cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:       if (!rx_s) state_next = START;
            START: begin
                if (at_decide && maj) begin
                    state_next = IDLE;
                end else if (cell_end) begin
                    state_next = DATA;
                end
            end
            DATA: begin
                if (cell_end && bit_idx == 3'd7) begin
                    state_next = (PARITY != 0) ? PARITY_BIT : STOP;
                end
            end
            PARITY_BIT: if (cell_end) state_next = STOP;
            // Leave STOP at the decision point so a following start bit is not missed.
            STOP:       if (at_decide) state_next = maj ? IDLE : WAIT_HIGH;
            WAIT_HIGH:  if (rx_s) state_next = IDLE;
            default:    state_next = IDLE;
        endcase
    end

    always_comb begin
        busy       = (state != IDLE) && (state != WAIT_HIGH);
        byte_done  = (state == STOP) && at_decide && maj;
        frame_bad  = (state == STOP) && at_decide && !maj;
        par_expect = (PARITY == 2) ? ~^shreg : ^shreg;
        par_bad    = (PARITY != 0) && (par_bit != par_expect);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1      <= 1'b1;
            rx_s       <= 1'b1;
            cnt        <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            samp_a     <= 1'b1;
            samp_b     <= 1'b1;
            par_bit    <= 1'b0;
            byte_out   <= '0;
            ready_out  <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            sync1      <= bit_in;
            rx_s       <= sync1;
            ready_out  <= byte_done;
            parity_err <= byte_done && par_bad;
            frame_err  <= frame_bad;

            if (byte_done) begin
                byte_out <= shreg;
            end

            // Counter is held at zero outside a frame so START always begins at cnt 0.
            if (!busy || cell_end) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 10'd1;
            end

            if (state != DATA) begin
                bit_idx <= '0;
            end else if (cell_end) begin
                bit_idx <= bit_idx + 3'd1;
            end

            if (busy && cnt == SAMP_A) samp_a <= rx_s;
            if (busy && cnt == SAMP_B) samp_b <= rx_s;

            if (state == DATA && at_decide) begin
                shreg <= {maj, shreg[7:1]};
            end
            if (state == PARITY_BIT && at_decide) begin
                par_bit <= maj;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_sampler.sv
// Directed bench for uart_rx_sampler: one instance without parity, one with even parity,
// with expected bytes, pulse counts and latencies worked out by hand.
module tb_uart_rx_sampler;

    localparam int C = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       line0 = 1'b1;
    logic       line1 = 1'b1;
    logic [7:0] byte0, byte1;
    logic       ready0, ready1, perr0, perr1, ferr0, ferr1, busy0, busy1;

    uart_rx_sampler #(.CLKS_PER_BIT(C), .PARITY(0)) dut0 (
        .clk(clk), .reset(reset), .bit_in(line0), .byte_out(byte0),
        .ready_out(ready0), .parity_err(perr0), .frame_err(ferr0), .busy(busy0)
    );

    uart_rx_sampler #(.CLKS_PER_BIT(C), .PARITY(1)) dut1 (
        .clk(clk), .reset(reset), .bit_in(line1), .byte_out(byte1),
        .ready_out(ready1), .parity_err(perr1), .frame_err(ferr1), .busy(busy1)
    );

    initial forever #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    int rdy_cnt0 = 0, rdy_cyc0 = 0, ferr_cnt0 = 0, perr_cnt0 = 0, rise_cnt0 = 0, rise_cyc0 = 0;
    int busy_hi0 = 0, dbl0 = 0;
    logic rdy_perr0 = 1'b0, ready0_prev = 1'b0, busy0_prev = 1'b0;
    logic [7:0] rdy_log0[$];

    int rdy_cnt1 = 0, rdy_cyc1 = 0, ferr_cnt1 = 0, perr_cnt1 = 0, rise_cyc1 = 0, dbl1 = 0;
    logic rdy_perr1 = 1'b0, ready1_prev = 1'b0, busy1_prev = 1'b0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Pulse monitor, sampled mid-cycle.
    initial forever begin
        @(negedge clk);
        if (ready0) begin
            rdy_cnt0++;
            rdy_cyc0 = cyc;
            rdy_perr0 = perr0;
            rdy_log0.push_back(byte0);
            if (ready0_prev) dbl0++;
        end
        if (perr0) perr_cnt0++;
        if (ferr0) ferr_cnt0++;
        if (busy0 && !busy0_prev) begin
            rise_cnt0++;
            rise_cyc0 = cyc;
        end
        if (busy0) busy_hi0++;
        ready0_prev = ready0;
        busy0_prev  = busy0;

        if (ready1) begin
            rdy_cnt1++;
            rdy_cyc1 = cyc;
            rdy_perr1 = perr1;
            if (ready1_prev) dbl1++;
        end
        if (perr1) perr_cnt1++;
        if (ferr1) ferr_cnt1++;
        if (busy1 && !busy1_prev) rise_cyc1 = cyc;
        ready1_prev = ready1;
        busy1_prev  = busy1;
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic setLine(input int which, input logic v);
        if (which == 0) line0 = v;
        else            line1 = v;
    endtask

    // Drives one frame; glitch_bit >= 0 inverts that data bit for the cycle landing on cnt=H.
    task automatic applyStimulus(input int which, input logic [7:0] data, input bit with_par,
                                 input logic par_bit, input logic stop_bit, input int glitch_bit);
        logic frame[$];
        logic v;
        frame.push_back(1'b0);
        for (int i = 0; i < 8; i++) frame.push_back(data[i]);
        if (with_par) frame.push_back(par_bit);
        frame.push_back(stop_bit);
        for (int k = 0; k < frame.size(); k++) begin
            for (int j = 0; j < C; j++) begin
                v = frame[k];
                if (k == glitch_bit + 1 && j == 9) v = ~v;
                setLine(which, v);
                @(posedge clk);
                #1;
            end
        end
    endtask

    int base_r, base_f, base_rise, base_hi, base_log;

    initial begin
        reset = 1'b0;
        waitCycles(3);
        checkOutput("rst_byte", 32'(byte0), 0);
        checkOutput("rst_ready", 32'(ready0), 0);
        checkOutput("rst_perr", 32'(perr0), 0);
        checkOutput("rst_ferr", 32'(ferr0), 0);
        checkOutput("rst_busy", 32'(busy0), 0);
        reset = 1'b1;
        waitCycles(5);

        base_r = rdy_cnt0; base_f = ferr_cnt0;
        applyStimulus(0, 8'hA5, 1'b0, 1'b0, 1'b1, -1);
        waitCycles(4);
        checkOutput("a5_count", rdy_cnt0 - base_r, 1);
        checkOutput("a5_byte", 32'(byte0), 'hA5);
        checkOutput("a5_latency", rdy_cyc0 - rise_cyc0, 154);
        checkOutput("a5_ferr", ferr_cnt0 - base_f, 0);
        checkOutput("a5_perr", 32'(rdy_perr0), 0);
        checkOutput("a5_busy_after", 32'(busy0), 0);

        base_r = rdy_cnt0; base_f = ferr_cnt0; base_rise = rise_cnt0; base_hi = busy_hi0;
        setLine(0, 1'b0);
        waitCycles(3);
        setLine(0, 1'b1);
        waitCycles(25);
        checkOutput("fs_busy_rise", rise_cnt0 - base_rise, 1);
        checkOutput("fs_busy_cycles", busy_hi0 - base_hi, 10);
        checkOutput("fs_busy_now", 32'(busy0), 0);
        checkOutput("fs_ready", rdy_cnt0 - base_r, 0);
        checkOutput("fs_ferr", ferr_cnt0 - base_f, 0);

        base_r = rdy_cnt0;
        applyStimulus(0, 8'h3C, 1'b0, 1'b0, 1'b1, 2);
        waitCycles(4);
        checkOutput("glitch_count", rdy_cnt0 - base_r, 1);
        checkOutput("glitch_byte", 32'(byte0), 'h3C);

        base_r = rdy_cnt0; base_f = ferr_cnt0; base_rise = rise_cnt0;
        applyStimulus(0, 8'h55, 1'b0, 1'b0, 1'b0, -1);
        waitCycles(40);
        checkOutput("brk_ferr", ferr_cnt0 - base_f, 1);
        checkOutput("brk_ready", rdy_cnt0 - base_r, 0);
        checkOutput("brk_byte_held", 32'(byte0), 'h3C);
        checkOutput("brk_busy_low", 32'(busy0), 0);
        setLine(0, 1'b1);
        waitCycles(20);
        checkOutput("brk_no_restart", rise_cnt0 - base_rise, 1);
        checkOutput("brk_busy_idle", 32'(busy0), 0);

        base_r = rdy_cnt0; base_log = rdy_log0.size();
        applyStimulus(0, 8'h81, 1'b0, 1'b0, 1'b1, -1);
        applyStimulus(0, 8'h7E, 1'b0, 1'b0, 1'b1, -1);
        waitCycles(4);
        checkOutput("b2b_count", rdy_cnt0 - base_r, 2);
        if (rdy_log0.size() >= base_log + 2) begin
            checkOutput("b2b_first", 32'(rdy_log0[base_log]), 'h81);
            checkOutput("b2b_second", 32'(rdy_log0[base_log + 1]), 'h7E);
        end else begin
            checkOutput("b2b_log_size", rdy_log0.size() - base_log, 2);
        end
        checkOutput("b2b_byte", 32'(byte0), 'h7E);

        // Start bit plus data bits 0..3 of a zero byte, then half of bit 4.
        base_r = rdy_cnt0;
        setLine(0, 1'b0);
        waitCycles(5 * C + 8);
        checkOutput("mid_busy", 32'(busy0), 1);
        reset = 1'b0;
        setLine(0, 1'b1);
        @(posedge clk);
        #1;
        checkOutput("mid_rst_byte", 32'(byte0), 0);
        checkOutput("mid_rst_ready", 32'(ready0), 0);
        checkOutput("mid_rst_perr", 32'(perr0), 0);
        checkOutput("mid_rst_ferr", 32'(ferr0), 0);
        checkOutput("mid_rst_busy", 32'(busy0), 0);
        reset = 1'b1;
        waitCycles(2 * C);
        checkOutput("mid_no_pulse", rdy_cnt0 - base_r, 0);
        applyStimulus(0, 8'h12, 1'b0, 1'b0, 1'b1, -1);
        waitCycles(4);
        checkOutput("mid_next_count", rdy_cnt0 - base_r, 1);
        checkOutput("mid_next_byte", 32'(byte0), 'h12);

        base_r = rdy_cnt1;
        applyStimulus(1, 8'h07, 1'b1, 1'b0, 1'b1, -1);
        waitCycles(4);
        checkOutput("par_count", rdy_cnt1 - base_r, 1);
        checkOutput("par_byte", 32'(byte1), 'h07);
        checkOutput("par_err", 32'(rdy_perr1), 1);
        checkOutput("par_latency", rdy_cyc1 - rise_cyc1, 170);
        applyStimulus(1, 8'h03, 1'b1, 1'b0, 1'b1, -1);
        waitCycles(4);
        checkOutput("par_ok_byte", 32'(byte1), 'h03);
        checkOutput("par_ok_err", 32'(rdy_perr1), 0);

        checkOutput("perr_total1", perr_cnt1, 1);
        checkOutput("ferr_total1", ferr_cnt1, 0);
        checkOutput("perr_total0", perr_cnt0, 0);
        checkOutput("ready_width0", dbl0, 0);
        checkOutput("ready_width1", dbl1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_rx_sampler.md
Name: uart_rx_sampler

Overview:
- 8-bit UART receive front end with a configurable number of clock cycles per bit and optional parity.
- Sits directly upstream of the UART byte buffer in the transit path, in the PLL-derived clock domain.
- Synchronises the raw serial line and majority-votes three samples at each bit centre.
- Delivers each received byte with a one-cycle ready pulse, and flags false starts, framing errors and parity errors.

Parameters:
- CLKS_PER_BIT, 16, clock cycles per serial bit; legal range 4..1023.
- PARITY, 0, parity mode: 0 = none, 1 = even, 2 = odd.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-low reset; sampled on posedge clk; clears all state when 0.
- bit_in  in  1  raw asynchronous serial line; idles high.
- byte_out  out  8  last successfully received byte; LSB is the first data bit on the line.
- ready_out  out  1  one-cycle pulse when byte_out has been updated.
- parity_err  out  1  one-cycle pulse, coincident with ready_out, when parity mismatches; always 0 when PARITY=0.
- frame_err  out  1  one-cycle pulse when the stop bit is sampled low.
- busy  out  1  high while a frame is in progress (any state except IDLE and WAIT_HIGH).

Behaviour:
- Reset (reset==0 at posedge):
  - byte_out=0, ready_out=0, parity_err=0, frame_err=0, busy=0.
  - Synchroniser flops are set to 1; state=IDLE; bit counter and cycle counter are cleared.
  - Reset mid-frame aborts the frame; no pulse is emitted.
- Synchroniser: bit_in passes through 2 flops to give rx_s; all decisions use rx_s.
- Bit timing:
  - Cycle counter cnt runs 0..CLKS_PER_BIT-1 within each bit cell.
  - Let H = CLKS_PER_BIT/2 (integer division).
  - Samples are taken at cnt = H-1, H and H+1; the bit value is the majority of the three.
  - The decision is made at cnt = H+1.
- States:
  - IDLE: when rx_s==0, go to START with cnt=0. That cycle is E, the start of cell 0.
  - START: at the decision point, if the majority is 1 this is a false start: go to IDLE with no pulse. Otherwise continue to the cell end, then go to DATA with bit index 0.
  - DATA: 8 cells. Each decided bit is shifted into the shift register MSB-first, so bit 0 ends at position [0]. After cell 7, go to PARITY if PARITY!=0, else to STOP.
  - PARITY: 1 cell. Compare the decided bit with the XOR of the data bits (even mode) or its inverse (odd mode).
  - STOP, at the decision point:
    - If the majority is 1: on the next cycle, byte_out <= shift register, ready_out=1, parity_err=mismatch. Go to IDLE immediately; the remaining half-cell is not waited out, so back-to-back frames are accepted.
    - If the majority is 0: on the next cycle, frame_err=1, byte_out is unchanged, ready_out=0. Go to WAIT_HIGH.
  - WAIT_HIGH: stay until rx_s==1, then go to IDLE. This blocks re-triggering on a break (line held low).
- Latency with PARITY=0: ready_out asserts at E + 9*CLKS_PER_BIT + H + 2. For CLKS_PER_BIT=16 this is E+154.
- Latency with PARITY!=0: add CLKS_PER_BIT.
- All pulses last exactly one cycle. byte_out holds its value between frames.
- Glitch rejection: a single-cycle deviation at any one of the three sample points does not change the decided bit.
- busy rises on the cycle after IDLE detects rx_s==0. It falls on the cycle ready_out or frame_err asserts, or on the cycle a false start returns to IDLE.

Test Plan:
- CLKS_PER_BIT=16, PARITY=0, send 0xA5 (start, 1,0,1,0,0,1,0,1, stop):
  - byte_out=0xA5, ready_out high for exactly 1 cycle, 154 cycles after the synced falling edge.
  - frame_err=0.
- Drive bit_in low for 3 cycles, then high:
  - busy returns to 0 after the START decision point.
  - No ready_out and no frame_err.
- Send 0x3C with a 1-cycle inverted glitch at cnt=H in data bit 2 → byte_out=0x3C, ready_out pulse.
- Send 0x55 with the stop bit held low, then line low for 40 cycles:
  - frame_err pulses once; byte_out keeps its previous value; no new frame starts until the line returns high.
- Send 0x81 and 0x7E back-to-back with one stop bit between them:
  - Two ready_out pulses; byte_out=0x81, then 0x7E.
- Cover the remaining reset and parity cases in one scenario:
  - Assert reset=0 for 1 cycle in the middle of data bit 4: all outputs are 0 and busy=0; the next full frame 0x12 is received correctly.
  - PARITY=1, send 0x07 with parity bit 0: ready_out and parity_err pulse together; byte_out=0x07.
